// File: rtl/multicycle_control.sv
// Main control FSM for the multi-cycle 32-bit MIPS datapath.
// Each instruction is sequenced through fetch, decode, execute, memory and
// writeback states. Datapath controls are decoded from the state register,
// so an asynchronous reset clears every enable in the same cycle. A few
// controls also follow the memory handshake directly:
//   - ir_write and pc_write in FETCH
//   - instr_done in MEM_WR
// ALUop for immediate-ALU instructions comes from a small register that is
// loaded in DECODE.
module multicycle_control #(
  parameter logic [5:0] OP_SUBI = 6'b001001,
  parameter logic [5:0] OP_SLTI = 6'b001010
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic [2:0] ALUop,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       branch_ne,
  output logic [1:0] pc_source,
  output logic       ir_write,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       byte_en,
  output logic       reg_write,
  output logic [1:0] reg_dst,
  output logic [1:0] mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       instr_done,
  output logic       illegal_op
);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_LB   = 6'b100000;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_SB   = 6'b101000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;

  localparam logic [2:0] ALU_AND  = 3'b000;
  localparam logic [2:0] ALU_OR   = 3'b001;
  localparam logic [2:0] ALU_SLT  = 3'b100;
  localparam logic [2:0] ALU_ADD  = 3'b101;
  localparam logic [2:0] ALU_SUB  = 3'b110;
  localparam logic [2:0] ALU_FUNC = 3'b111;

  typedef enum logic [3:0] {
    S_RST      = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_EXEC_R   = 4'd3,
    S_WB_R     = 4'd4,
    S_EXEC_I   = 4'd5,
    S_WB_I     = 4'd6,
    S_MEM_ADDR = 4'd7,
    S_MEM_RD   = 4'd8,
    S_MEM_WB   = 4'd9,
    S_MEM_WR   = 4'd10,
    S_BRANCH   = 4'd11,
    S_JUMP     = 4'd12,
    S_ILLEGAL  = 4'd13
  } state_t;

  state_t     state_r;
  logic [2:0] aluop_r;    // ALU operation of the immediate-ALU instruction
  logic       is_load_r;  // lw/lb (vs. sw/sb) for the memory path
  logic       is_byte_r;  // lb/sb byte access
  logic       is_bne_r;   // bne (vs. beq)
  logic       is_jal_r;   // jal links into $ra

  // True for the immediate-ALU instructions that use the latched ALUop.
  function automatic logic is_ialu(input logic [5:0] op);
    logic r;
    r = 1'b0;
    if (op == OP_ADDI || op == OP_SUBI || op == OP_ANDI ||
        op == OP_ORI  || op == OP_SLTI) begin
      r = 1'b1;
    end
    return r;
  endfunction

  // ALU operation selected by an immediate-ALU opcode.
  function automatic logic [2:0] ialu_op(input logic [5:0] op);
    logic [2:0] r;
    r = ALU_ADD;
    if (op == OP_SUBI) begin
      r = ALU_SUB;
    end else if (op == OP_ANDI) begin
      r = ALU_AND;
    end else if (op == OP_ORI) begin
      r = ALU_OR;
    end else if (op == OP_SLTI) begin
      r = ALU_SLT;
    end else begin
      r = ALU_ADD;
    end
    return r;
  endfunction

  // State sequencing plus the per-instruction flags captured in DECODE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= S_RST;
      aluop_r   <= 3'b000;
      is_load_r <= 1'b0;
      is_byte_r <= 1'b0;
      is_bne_r  <= 1'b0;
      is_jal_r  <= 1'b0;
    end else begin
      case (state_r)
        S_RST: begin
          state_r <= S_FETCH;
        end

        S_FETCH: begin
          if (mem_ready) begin
            state_r <= S_DECODE;
          end else begin
            state_r <= S_FETCH;
          end
        end

        S_DECODE: begin
          is_load_r <= (opcode == OP_LW) || (opcode == OP_LB);
          is_byte_r <= (opcode == OP_LB) || (opcode == OP_SB);
          is_bne_r  <= (opcode == OP_BNE);
          is_jal_r  <= (opcode == OP_JAL);
          if (is_ialu(opcode)) begin
            aluop_r <= ialu_op(opcode);
          end else begin
            aluop_r <= aluop_r;
          end
          if (opcode == OP_R) begin
            state_r <= S_EXEC_R;
          end else if (opcode == OP_LW || opcode == OP_LB ||
                       opcode == OP_SW || opcode == OP_SB) begin
            state_r <= S_MEM_ADDR;
          end else if (opcode == OP_BEQ || opcode == OP_BNE) begin
            state_r <= S_BRANCH;
          end else if (is_ialu(opcode)) begin
            state_r <= S_EXEC_I;
          end else if (opcode == OP_J || opcode == OP_JAL) begin
            state_r <= S_JUMP;
          end else begin
            state_r <= S_ILLEGAL;
          end
        end

        S_EXEC_R: begin
          state_r <= S_WB_R;
        end

        S_EXEC_I: begin
          state_r <= S_WB_I;
        end

        S_MEM_ADDR: begin
          if (is_load_r) begin
            state_r <= S_MEM_RD;
          end else begin
            state_r <= S_MEM_WR;
          end
        end

        S_MEM_RD: begin
          if (mem_ready) begin
            state_r <= S_MEM_WB;
          end else begin
            state_r <= S_MEM_RD;
          end
        end

        S_MEM_WR: begin
          if (mem_ready) begin
            state_r <= S_FETCH;
          end else begin
            state_r <= S_MEM_WR;
          end
        end

        S_WB_R, S_WB_I, S_MEM_WB, S_BRANCH, S_JUMP, S_ILLEGAL: begin
          state_r <= S_FETCH;
        end

        default: begin
          state_r <= S_RST;
        end
      endcase
    end
  end

  // Moore decode of the datapath controls from the current state.
  always_comb begin
    ALUop         = 3'b000;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    branch_ne     = 1'b0;
    pc_source     = 2'b00;
    ir_write      = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    byte_en       = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = 2'b00;
    mem_to_reg    = 2'b00;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    instr_done    = 1'b0;
    illegal_op    = 1'b0;
    case (state_r)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ALUop     = ALU_ADD;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end

      S_DECODE: begin
        alu_src_b = 2'b11;
        ALUop     = ALU_ADD;
      end

      S_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b00;
        ALUop     = ALU_FUNC;
      end

      S_WB_R: begin
        reg_write  = 1'b1;
        reg_dst    = 2'b01;
        instr_done = 1'b1;
      end

      S_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        ALUop     = aluop_r;
      end

      S_WB_I: begin
        ALUop      = aluop_r;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end

      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        ALUop     = ALU_ADD;
      end

      S_MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        byte_en  = is_byte_r;
      end

      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 2'b01;
        instr_done = 1'b1;
      end

      S_MEM_WR: begin
        mem_write  = 1'b1;
        i_or_d     = 1'b1;
        byte_en    = is_byte_r;
        instr_done = mem_ready;
      end

      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_src_b     = 2'b00;
        ALUop         = ALU_SUB;
        pc_write_cond = 1'b1;
        branch_ne     = is_bne_r;
        pc_source     = 2'b01;
        instr_done    = 1'b1;
      end

      S_JUMP: begin
        pc_write   = 1'b1;
        pc_source  = 2'b10;
        instr_done = 1'b1;
        if (is_jal_r) begin
          reg_write  = 1'b1;
          reg_dst    = 2'b10;
          mem_to_reg = 2'b10;
        end else begin
          reg_write  = 1'b0;
        end
      end

      S_ILLEGAL: begin
        illegal_op = 1'b1;
      end

      default: begin
        ALUop = 3'b000;
      end
    endcase
  end

endmodule
